// File: rtl/isa_pkg.sv
// isa_pkg: shared definitions for the ISA I/O cycle engine.
//   state_e        - cycle FSM states
//   CTL_*          - bit positions inside control_in
//   DIR_*          - encodings of the DIR control bit
//   max4()         - helper used to size the phase counter
package isa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_STROBE   = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_HOLD     = 3'd4
  } state_e;

  localparam int CTL_GO   = 0;
  localparam int CTL_DIR  = 1;
  localparam int CTL_IO16 = 2;

  localparam logic DIR_WRITE = 1'b0;
  localparam logic DIR_READ  = 1'b1;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/isa_sync.sv
// isa_sync: two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk_i   - system clock
//   reset_i - synchronous active-high reset, output clears to 0
//   d_i     - asynchronous input
//   q_o     - synchronized output, two clocks of latency
module isa_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/isa_cycle_engine.sv
// isa_cycle_engine: turns a GO request from the register file into one ISA
// I/O bus cycle (SETUP -> STROBE -> [WAIT_RDY] -> HOLD) with IOCHRDY wait
// states, and returns read data with a one-clock load pulse.
// Optional build macro: ISA_TIMEOUT_EN bounds WAIT_RDY to RDY_TIMEOUT clocks
// and reports an abort on the sticky timeout_err output.
// Ports:
//   clk, reset                 - system clock, synchronous active-high reset
//   address_in/data_in         - port address and write data (latched at start)
//   control_in                 - [0] GO, [1] DIR (1=read), [2] IO16
//   isa_sd_in, isa_iochrdy     - ISA data in and asynchronous ready
//   isa_sa, isa_sd_out/_oe     - ISA address, write data and its enable
//   isa_ior_n, isa_iow_n       - active-low I/O strobes
//   isa_sbhe_n                 - active-low byte-high enable
//   read_data, read_data_load  - captured read data and its load pulse
//   busy, done, timeout_err    - cycle status
module isa_cycle_engine
  import isa_pkg::*;
#(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 8,
  parameter int HOLD_CYCLES   = 2,
  parameter int RDY_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address_in,
  input  logic [15:0] data_in,
  input  logic [7:0]  control_in,
  input  logic [15:0] isa_sd_in,
  input  logic        isa_iochrdy,
  output logic [15:0] isa_sa,
  output logic [15:0] isa_sd_out,
  output logic        isa_sd_oe,
  output logic        isa_ior_n,
  output logic        isa_iow_n,
  output logic        isa_sbhe_n,
  output logic [15:0] read_data,
  output logic        read_data_load,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam int CNT_MAX = max4(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES, RDY_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  // Each phase loads (length-1) and ends when the down-counter reaches zero.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
`ifdef ISA_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WAIT_LD   = CNT_W'(RDY_TIMEOUT - 1);
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              go_q;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              dir_q, dir_d;
  logic              io16_q, io16_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              load_q, load_d;
  logic              done_q, done_d;
  logic              rdy_sync;
  logic              go_rise;
  logic              cnt_zero;
  logic              finish_strobe;
  logic              strobe_on;
  logic              ctl_unused;

  assign ctl_unused = ^control_in[7:3];

  isa_sync u_rdy_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (isa_iochrdy),
    .q_o     (rdy_sync)
  );

  assign go_rise  = control_in[CTL_GO] & ~go_q;
  assign cnt_zero = (cnt_q == '0);

`ifdef ISA_TIMEOUT_EN
  logic terr_q, terr_d;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    dir_d         = dir_q;
    io16_d        = io16_q;
    rdata_d       = rdata_q;
    load_d        = 1'b0;
    done_d        = 1'b0;
    finish_strobe = 1'b0;
`ifdef ISA_TIMEOUT_EN
    terr_d        = terr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (go_rise) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          addr_d  = address_in;
          dir_d   = control_in[CTL_DIR];
          io16_d  = control_in[CTL_IO16];
          wdata_d = control_in[CTL_IO16] ? data_in : {8'h00, data_in[7:0]};
`ifdef ISA_TIMEOUT_EN
          terr_d  = 1'b0;
`endif
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rdy_sync) begin
          finish_strobe = 1'b1;
        end else begin
          state_d = ST_WAIT_RDY;
`ifdef ISA_TIMEOUT_EN
          cnt_d   = WAIT_LD;
`endif
        end
      end
      ST_WAIT_RDY: begin
        if (rdy_sync) begin
          finish_strobe = 1'b1;
        end
`ifdef ISA_TIMEOUT_EN
        // Ready on the last permitted wait clock still completes normally.
        else if (cnt_zero) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`endif
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Data is sampled on the last strobe-low clock; the load pulse lands on
    // the first HOLD clock.
    if (finish_strobe) begin
      state_d = ST_HOLD;
      cnt_d   = HOLD_LD;
      if (dir_q == DIR_READ) begin
        rdata_d = io16_q ? isa_sd_in : {8'h00, isa_sd_in[7:0]};
        load_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      go_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dir_q   <= DIR_WRITE;
      io16_q  <= 1'b0;
      rdata_q <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      go_q    <= control_in[CTL_GO];
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dir_q   <= dir_d;
      io16_q  <= io16_d;
      rdata_q <= rdata_d;
      load_q  <= load_d;
      done_q  <= done_d;
    end
  end

`ifdef ISA_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) terr_q <= 1'b0;
    else       terr_q <= terr_d;
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign busy           = (state_q != ST_IDLE);
  assign strobe_on      = (state_q == ST_STROBE) || (state_q == ST_WAIT_RDY);
  assign isa_ior_n      = ~(strobe_on && (dir_q == DIR_READ));
  assign isa_iow_n      = ~(strobe_on && (dir_q == DIR_WRITE));
  assign isa_sd_oe      = busy && (dir_q == DIR_WRITE);
  assign isa_sbhe_n     = ~(busy && io16_q);
  assign isa_sa         = addr_q;
  assign isa_sd_out     = wdata_q;
  assign read_data      = rdata_q;
  assign read_data_load = load_q;
  assign done           = done_q;

endmodule

// File: tb/tb_isa_cycle_engine.sv
module tb_isa_cycle_engine;

  localparam int SETUP  = 2;
  localparam int STROBE = 8;
  localparam int HOLD   = 2;
  localparam int RDY_TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address_in = '0;
  logic [15:0] data_in = '0;
  logic [7:0]  control_in = '0;
  logic [15:0] isa_sd_in = '0;
  logic        isa_iochrdy = 1'b1;
  logic [15:0] isa_sa, isa_sd_out, read_data;
  logic        isa_sd_oe, isa_ior_n, isa_iow_n, isa_sbhe_n;
  logic        read_data_load, busy, done, timeout_err;

  always #5 clk = ~clk;

  isa_cycle_engine #(
    .SETUP_CYCLES (SETUP),
    .STROBE_CYCLES(STROBE),
    .HOLD_CYCLES  (HOLD),
    .RDY_TIMEOUT  (RDY_TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .address_in    (address_in),
    .data_in       (data_in),
    .control_in    (control_in),
    .isa_sd_in     (isa_sd_in),
    .isa_iochrdy   (isa_iochrdy),
    .isa_sa        (isa_sa),
    .isa_sd_out    (isa_sd_out),
    .isa_sd_oe     (isa_sd_oe),
    .isa_ior_n     (isa_ior_n),
    .isa_iow_n     (isa_iow_n),
    .isa_sbhe_n    (isa_sbhe_n),
    .read_data     (read_data),
    .read_data_load(read_data_load),
    .busy          (busy),
    .done          (done),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wbus;
    bit          rd;
    bit          io16;
    logic [15:0] rdata;
    int          loads;
    int          strobe_len;
    int          busy_len;
    bit          terr;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: ready held low for L strobe clocks reaches the FSM two clocks
  // late, so the strobe ends two clocks after ready returns, never sooner
  // than the programmed minimum.
  function automatic exp_t model(input logic [15:0] addr, input logic [15:0] data,
                                 input bit rd, input bit io16,
                                 input logic [15:0] sdin, input int L);
    exp_t e;
    int   len;
    bit   terr;
    len  = STROBE;
    if (L > 0 && L + 3 > len) len = L + 3;
    terr = 1'b0;
`ifdef ISA_TIMEOUT_EN
    if (len > STROBE + RDY_TO) begin
      len  = STROBE + RDY_TO;
      terr = 1'b1;
    end
`endif
    e.addr       = addr;
    e.wbus       = io16 ? data : (data & 16'h00FF);
    e.rd         = rd;
    e.io16       = io16;
    e.rdata      = io16 ? sdin : (sdin & 16'h00FF);
    e.loads      = (rd && !terr) ? 1 : 0;
    e.strobe_len = len;
    e.busy_len   = SETUP + len + HOLD;
    e.terr       = terr;
    return e;
  endfunction

  // Monitor / scoreboard checker
  int          m_busy = 0, m_ior = 0, m_iow = 0, m_load = 0, m_bad = 0;
  logic [15:0] m_rdata = '0;
  exp_t        me;

  always @(negedge clk) begin
    if (reset) begin
      m_busy = 0; m_ior = 0; m_iow = 0; m_load = 0; m_bad = 0;
    end else begin
      if (busy) begin
        m_busy++;
        if (!isa_ior_n) m_ior++;
        if (!isa_iow_n) m_iow++;
        if (sb.size() > 0) begin
          me = sb[0];
          if (isa_sa !== me.addr) m_bad++;
          if (isa_sd_oe !== !me.rd) m_bad++;
          if (!me.rd && isa_sd_out !== me.wbus) m_bad++;
          if (isa_sbhe_n !== !me.io16) m_bad++;
        end
      end
      if (read_data_load) begin
        m_load++;
        m_rdata = read_data;
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          me = sb.pop_front();
          check("busy_len", m_busy, me.busy_len);
          check("ior_low_clocks", m_ior, me.rd ? me.strobe_len : 0);
          check("iow_low_clocks", m_iow, me.rd ? 0 : me.strobe_len);
          check("load_pulses", m_load, me.loads);
          if (me.loads > 0) check("read_data", m_rdata, me.rdata);
          check("bus_drive_errors", m_bad, 0);
          check("timeout_err", timeout_err, me.terr);
          check("busy_with_done", busy, 0);
        end
        m_busy = 0; m_ior = 0; m_iow = 0; m_load = 0; m_bad = 0;
      end
    end
  end

  task automatic issue(input logic [15:0] addr, input logic [15:0] data, input bit rd,
                       input bit io16, input logic [15:0] sdin, input int L, input bit toggle);
    sb.push_back(model(addr, data, rd, io16, sdin, L));
    address_in = addr;
    data_in    = data;
    isa_sd_in  = sdin;
    control_in = {5'b00000, io16, rd, 1'b1};
    @(posedge clk); #1;
    // Scramble inputs after the start edge: the cycle must use latched values.
    address_in = 16'($urandom);
    data_in    = 16'($urandom);
    control_in = 8'($urandom) & 8'hFE;
    fork
      begin
        repeat (SETUP) @(posedge clk);
        #1;
        if (L > 0) begin
          isa_iochrdy = 1'b0;
          repeat (L) @(posedge clk);
          #1;
          isa_iochrdy = 1'b1;
        end
      end
      begin
        if (toggle) begin
          repeat (SETUP + 1) @(posedge clk);
          #1; control_in[0] = 1'b1;
          @(posedge clk); #1; control_in[0] = 1'b0;
          @(posedge clk); #1; control_in[0] = 1'b1;
        end
      end
      begin : wait_done
        bit got;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
          @(posedge clk); #1;
          if (done) got = 1'b1;
        end
        if (!got) check("done_wait_timeout", 32'd0, 32'd1);
      end
    join
    if (toggle) begin
      repeat (4) @(posedge clk);
      #1; control_in[0] = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_isa_sa", isa_sa, 16'h0);
    check("rst_isa_sd_out", isa_sd_out, 16'h0);
    check("rst_isa_sd_oe", isa_sd_oe, 1'b0);
    check("rst_isa_ior_n", isa_ior_n, 1'b1);
    check("rst_isa_iow_n", isa_iow_n, 1'b1);
    check("rst_isa_sbhe_n", isa_sbhe_n, 1'b1);
    check("rst_read_data", read_data, 16'h0);
    check("rst_read_data_load", read_data_load, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    issue(16'h0220, 16'hA55A, 1'b0, 1'b1, 16'h0000, 0, 1'b0);
    issue(16'h022A, 16'h0000, 1'b1, 1'b0, 16'h1234, 0, 1'b0);
    issue(16'h0300, 16'h5A5A, 1'b1, 1'b1, 16'hBEEF, 20, 1'b0);
    issue(16'h0301, 16'h1357, 1'b0, 1'b0, 16'h0000, 0, 1'b1);
`ifdef ISA_TIMEOUT_EN
    issue(16'h0310, 16'h0000, 1'b1, 1'b1, 16'hCAFE, 40, 1'b0);
    issue(16'h0311, 16'h4242, 1'b0, 1'b1, 16'h0000, 0, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      int L;
      int gap;
      L   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
      gap = $urandom_range(0, 3);
      issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
            L, ($urandom_range(0, 7) == 0));
      repeat (gap) @(posedge clk);
      #1;
    end

    // Abort a cycle stalled in WAIT_RDY with reset; nothing is queued for it.
    repeat (2) @(posedge clk);
    #1;
    address_in = 16'h0BAD;
    data_in    = 16'hFFFF;
    isa_sd_in  = 16'h7777;
    control_in = 8'h07;
    @(posedge clk); #1;
    control_in = 8'h00;
    repeat (SETUP) @(posedge clk);
    #1; isa_iochrdy = 1'b0;
    repeat (STROBE + 3) @(posedge clk);
    #1;
    check("stall_busy", busy, 1'b1);
    check("stall_ior_n", isa_ior_n, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_isa_sa", isa_sa, 16'h0);
    check("mid_rst_isa_sd_oe", isa_sd_oe, 1'b0);
    check("mid_rst_isa_ior_n", isa_ior_n, 1'b1);
    check("mid_rst_isa_iow_n", isa_iow_n, 1'b1);
    check("mid_rst_isa_sbhe_n", isa_sbhe_n, 1'b1);
    check("mid_rst_read_data", read_data, 16'h0);
    check("mid_rst_load", read_data_load, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_timeout_err", timeout_err, 1'b0);
    reset = 1'b0;
    isa_iochrdy = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_idle", busy, 1'b0);
    check("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/isa_cycle_engine.md
# isa_cycle_engine

Downstream consumer of the register file's address, data and control outputs. Converts a host-issued transfer request into a single ISA I/O bus cycle toward the CT2960 card: it drives SA/SD, sequences IOR#/IOW# with programmable setup, strobe and hold phases, honours IOCHRDY wait states, and returns read data via a load pulse into the data register's read-side port.

## Interface
- SETUP_CYCLES, 2: clocks from address-valid to strobe assertion (≥1)
- STROBE_CYCLES, 8: minimum strobe-low clocks (≥1)
- HOLD_CYCLES, 2: clocks address/data held after strobe release (≥1)
- RDY_TIMEOUT, 255: maximum wait-state clocks when the timeout feature is compiled in (≥1)
- clk  in  1  single system clock
- reset  in  1  synchronous, active-high
- address_in  in  16  I/O port address from the register file
- data_in  in  16  write data from the register file
- control_in  in  8  bit0 GO, bit1 DIR (1=read, 0=write), bit2 IO16; bits 7:3 ignored
- isa_sd_in  in  16  ISA data bus input
- isa_iochrdy  in  1  ISA ready, asynchronous
- isa_sa  out  16  ISA address
- isa_sd_out  out  16  ISA write data
- isa_sd_oe  out  1  SD output enable
- isa_ior_n, isa_iow_n  out  1 each  ISA I/O strobes, active-low
- isa_sbhe_n  out  1  byte-high enable, active-low
- read_data  out  16  captured read data
- read_data_load  out  1  one-clock pulse; loads read_data into the data register
- busy  out  1  cycle in progress
- done  out  1  one-clock pulse at cycle end
- timeout_err  out  1  sticky; last cycle aborted on timeout

## Operation
- States: IDLE, SETUP, STROBE, WAIT_RDY, HOLD.
- Start: in IDLE, control_in[0]=1 while the registered previous GO =0 (rising edge). GO edges outside IDLE are discarded, not queued.
- At start: latch address_in, data_in, DIR, IOW16 into internal registers; later input changes do not affect the cycle. Clear timeout_err.
- SETUP: isa_sa driven; for writes isa_sd_oe=1 and isa_sd_out valid; strobes high; SETUP_CYCLES clocks.
- STROBE: IOR# (read) or IOW# (write) low for STROBE_CYCLES clocks. On the last clock, synchronized IOCHRDY=1 → HOLD, else → WAIT_RDY.
- WAIT_RDY: strobe stays low until synchronized IOCHRDY=1, then → HOLD.
- Read capture: isa_sd_in sampled into read_data on the final strobe-low clock; read_data_load pulses on the first HOLD clock. 8-bit read: read_data[15:8]=0.
- HOLD: strobes high, isa_sa and write data still driven for HOLD_CYCLES clocks; then → IDLE, done pulses, isa_sd_oe=0.
- Width: IO16=1 → isa_sbhe_n=0, full 16 bits. IO16=0 → isa_sbhe_n=1, isa_sd_out[15:8]=0.
- Reset mid-cycle: next edge forces IDLE, strobes high, isa_sd_oe=0; no done, no read_data_load.

## Timing
- Reset values: isa_sa=0, isa_sd_out=0, isa_sd_oe=0, isa_ior_n=1, isa_iow_n=1, isa_sbhe_n=1, read_data=0, read_data_load=0, busy=0, done=0, timeout_err=0.
- GO edge at clock N → busy=1 and SETUP from N+1.
- IOCHRDY passes a 2-flop synchronizer: 2-clock latency before the FSM sees it.
- Zero-wait cycle length: SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES clocks; done on the clock after the final HOLD clock; busy falls with done.
- Counters sized to $clog2(max parameter)+1 bits; no wrap-around within a phase.
- Back-to-back: a GO edge on the done clock is accepted (state is IDLE).

## Configuration
- ISA_TIMEOUT_EN defined: WAIT_RDY counts clocks; after RDY_TIMEOUT clocks without ready → HOLD with timeout_err=1; done still pulses; read_data_load suppressed on reads.
- Not defined: WAIT_RDY waits indefinitely; timeout_err tied 0; no wait counter.

## Structure
- Package isa_pkg: state enum, control bit indices (CTL_GO=0, CTL_DIR=1, CTL_IO16=2), DIR encodings.
- Sub-module isa_sync: 2-flop synchronizer for isa_iochrdy, synchronous reset to 0.

## Test plan
- 16-bit write, addr 0x0220, data 0xA55A, IOCHRDY=1, defaults → IOW# low exactly 8 clocks, sbhe_n=0, SD=0xA55A from SETUP to end of HOLD, done after 12 clocks.
- 8-bit read 0x022A, bus returns 0x1234 → read_data=0x0034, one read_data_load pulse, IOR# low 8 clocks, sd_oe never 1.
- IOCHRDY low 20 clocks from strobe start → strobe extended by wait states until 2 clocks after ready rises; single done.
- ISA_TIMEOUT_EN, RDY_TIMEOUT=16, IOCHRDY held low → abort after 16 wait clocks, timeout_err=1, no read_data_load; next GO clears it.
- GO toggled during STROBE, then held high → ignored; no second cycle until GO falls and rises.
- Reset asserted in WAIT_RDY → next clock all outputs at reset values, no done.
